// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Lets two requesters (e.g. the EX stage and a multi-cycle helper) share a
//   single combinational ALU. A round-robin arbiter picks one request, the
//   chosen operands are registered onto the alu_* outputs, the ALU result is
//   captured one cycle later and returned to the winning requester over a
//   valid/ready response channel. Only one operation is in flight at a time.
//
// Parameters:
//   WIDTH  operand/result width
//   CTL_W  ALU control code width
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid_x / req_ready_x  request handshake for requester x (0 or 1)
//   req_in1_x, req_in2_x       operands (in1 is the shift amount for shifts)
//   req_ctl_x, req_sign_x      ALU control code and signed-compare select
//   rsp_valid_x / rsp_ready_x  response handshake for requester x
//   rsp_data_x                 result for requester x (0 when not valid)
//   alu_in1, alu_in2           registered operands to the shared ALU
//   alu_ctl, alu_sign          registered control code / sign select to ALU
//   alu_out                    combinational ALU result
//   conflict_cnt               (only with ALU_ARB_STATS_EN) saturating count of
//                              IDLE cycles in which both requesters were valid
//
// Build option:
//   `define ALU_ARB_STATS_EN to add the conflict_cnt statistics port.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_in1_0,
  input  logic [WIDTH-1:0] req_in2_0,
  input  logic [CTL_W-1:0] req_ctl_0,
  input  logic             req_sign_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_data_0,

  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_in1_1,
  input  logic [WIDTH-1:0] req_in2_1,
  input  logic [CTL_W-1:0] req_ctl_1,
  input  logic             req_sign_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_data_1,

  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             alu_sign,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      conflict_cnt,
`endif
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             lastGrant_q;
  logic             owner_q;
  logic [WIDTH-1:0] result_q;

  logic             grant_d;
  logic             anyValid;
  logic             accept;
  logic             ownerReady;
  logic [WIDTH-1:0] selIn1;
  logic [WIDTH-1:0] selIn2;
  logic [CTL_W-1:0] selCtl;
  logic             selSign;

  // Round-robin pick: a lone requester always wins; on a tie the requester
  // that was not granted last time goes first. Reset leaves lastGrant_q at 1
  // so requester 0 wins the very first tie.
  always_comb begin
    anyValid = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      grant_d = ~lastGrant_q;
    end else begin
      grant_d = req_valid_1;
    end
    selIn1  = grant_d ? req_in1_1  : req_in1_0;
    selIn2  = grant_d ? req_in2_1  : req_in2_0;
    selCtl  = grant_d ? req_ctl_1  : req_ctl_0;
    selSign = grant_d ? req_sign_1 : req_sign_0;
  end

  // Ready is only offered from IDLE, and rst_n gates it so nothing looks
  // accepted while the block is held in reset.
  assign accept      = rst_n & (state_q == IDLE) & anyValid;
  assign req_ready_0 = accept & ~grant_d;
  assign req_ready_1 = accept &  grant_d;

  assign ownerReady  = owner_q ? rsp_ready_1 : rsp_ready_0;

  // Main sequencer: IDLE latches the granted operation onto the ALU inputs,
  // EXEC samples the ALU result, RESP holds the result until the owner takes
  // it. A reset anywhere drops the operation without any response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      result_q    <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_ctl     <= '0;
      alu_sign    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyValid) begin
            alu_in1     <= selIn1;
            alu_in2     <= selIn2;
            alu_ctl     <= selCtl;
            alu_sign    <= selSign;
            owner_q     <= grant_d;
            lastGrant_q <= grant_d;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_out;
          state_q  <= RESP;
        end
        RESP: begin
          if (ownerReady) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Only the owner sees the response; the other side reads valid=0, data=0.
  assign rsp_valid_0 = (state_q == RESP) & ~owner_q;
  assign rsp_valid_1 = (state_q == RESP) &  owner_q;
  assign rsp_data_0  = rsp_valid_0 ? result_q : '0;
  assign rsp_data_1  = rsp_valid_1 ? result_q : '0;

`ifdef ALU_ARB_STATS_EN
  // Counts IDLE cycles in which both requesters compete, sticking at the
  // maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if ((state_q == IDLE) && req_valid_0 && req_valid_1 &&
                 (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. The bench provides the shared
// ALU itself (add=0, sub=1, arithmetic right shift=10, set-less-than=11,
// everything else returns 0) and checks results, routing, latency,
// arbitration order and reset behaviour. Inputs change on the falling edge
// and outputs are sampled 1ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        reqValid [2];
  logic        reqReady [2];
  logic [31:0] reqIn1   [2];
  logic [31:0] reqIn2   [2];
  logic [3:0]  reqCtl   [2];
  logic        reqSign  [2];
  logic        rspValid [2];
  logic        rspReady [2];
  logic [31:0] rspData  [2];
  logic [31:0] aluIn1;
  logic [31:0] aluIn2;
  logic [3:0]  aluCtl;
  logic        aluSign;
  logic [31:0] aluOut;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] conflictCnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  alu_share_arbiter #(.WIDTH(32), .CTL_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_0 (reqValid[0]),
    .req_ready_0 (reqReady[0]),
    .req_in1_0   (reqIn1[0]),
    .req_in2_0   (reqIn2[0]),
    .req_ctl_0   (reqCtl[0]),
    .req_sign_0  (reqSign[0]),
    .rsp_valid_0 (rspValid[0]),
    .rsp_ready_0 (rspReady[0]),
    .rsp_data_0  (rspData[0]),
    .req_valid_1 (reqValid[1]),
    .req_ready_1 (reqReady[1]),
    .req_in1_1   (reqIn1[1]),
    .req_in2_1   (reqIn2[1]),
    .req_ctl_1   (reqCtl[1]),
    .req_sign_1  (reqSign[1]),
    .rsp_valid_1 (rspValid[1]),
    .rsp_ready_1 (rspReady[1]),
    .rsp_data_1  (rspData[1]),
    .alu_in1     (aluIn1),
    .alu_in2     (aluIn2),
    .alu_ctl     (aluCtl),
    .alu_sign    (aluSign),
`ifdef ALU_ARB_STATS_EN
    .conflict_cnt(conflictCnt),
`endif
    .alu_out     (aluOut)
  );

  // Free-running 100MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour, written straight from the operation definitions.
  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c, input logic s);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd10:   return 32'($signed(b) >>> a[4:0]);
      4'd11:   return s ? (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)
                        : ((a < b) ? 32'd1 : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU sitting behind the arbiter.
  assign aluOut = refAlu(aluIn1, aluIn2, aluCtl, aluSign);

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one requester's operation fields and raises its valid.
  task automatic applyStimulus(input int side, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] c, input logic s);
    reqIn1[side]   = a;
    reqIn2[side]   = b;
    reqCtl[side]   = c;
    reqSign[side]  = s;
    reqValid[side] = 1'b1;
  endtask

  // Pulses reset for two cycles, releasing it on a falling edge.
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one operation on a single requester and reports what was observed.
  task automatic runOp(input int side, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic s,
                       output bit accepted, output bit earlyValid, output bit gotValid,
                       output logic [31:0] data, output bit otherValid,
                       output logic [31:0] snapIn1, output logic [31:0] snapIn2);
    int waited;
    @(negedge clk);
    applyStimulus(side, a, b, c, s);
    #1;
    waited = 0;
    while (!reqReady[side] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    accepted = reqReady[side];
    earlyValid = 1'b0;
    gotValid = 1'b0;
    data = '0;
    otherValid = 1'b0;
    snapIn1 = '0;
    snapIn2 = '0;
    if (!accepted) begin
      reqValid[side] = 1'b0;
      return;
    end
    @(negedge clk);
    reqValid[side] = 1'b0;
    #1;
    earlyValid = rspValid[side];
    snapIn1 = aluIn1;
    snapIn2 = aluIn2;
    @(negedge clk);
    #1;
    gotValid = rspValid[side];
    data = rspData[side];
    otherValid = rspValid[1 - side];
    rspReady[side] = 1'b1;
    @(negedge clk);
    rspReady[side] = 1'b0;
  endtask

  // Everything must read zero while reset is held, even with requests valid.
  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(0, 32'd1, 32'd2, 4'd0, 1'b0);
    applyStimulus(1, 32'd3, 32'd4, 4'd1, 1'b0);
    @(negedge clk);
    #1;
    checkCount++;
    if ({reqReady[0], reqReady[1], rspValid[0], rspValid[1]} !== 4'b0000)
      $display("[TB] FAIL reset_handshake: got %b, expected 0000",
               {reqReady[0], reqReady[1], rspValid[0], rspValid[1]});
    else passCount++;
    checkCount++;
    if ({aluIn1, aluIn2, aluCtl, aluSign, rspData[0], rspData[1]} !== '0)
      $display("[TB] FAIL reset_data: got in1=%h in2=%h ctl=%h sign=%b d0=%h d1=%h, expected all 0",
               aluIn1, aluIn2, aluCtl, aluSign, rspData[0], rspData[1]);
    else passCount++;
    reqValid[0] = 1'b0;
    reqValid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Both requesters valid right after reset; grants must alternate starting
  // with requester 0 and each result must come back to its own requester.
  task automatic test_contention();
    logic [31:0] opA [2][4];
    logic [31:0] opB [2][4];
    logic [31:0] expQ0[$];
    logic [31:0] expQ1[$];
    logic [31:0] expData;
    int cnt [2];
    bit pend [2];
    bit lastG;
    bit g;
    bit expG;
    int conflicts;
    int cycles;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        opA[s][i] = $urandom;
        opB[s][i] = $urandom;
      end
      cnt[s] = 0;
      pend[s] = 1'b0;
    end
    applyReset();
    applyStimulus(0, opA[0][0], opB[0][0], 4'd0, 1'b0);
    applyStimulus(1, opA[1][0], opB[1][0], 4'd1, 1'b0);
    rspReady[0] = 1'b1;
    rspReady[1] = 1'b1;
    lastG = 1'b1;
    conflicts = 0;
    cycles = 0;
    while ((cnt[0] < 4 || cnt[1] < 4 || expQ0.size() != 0 || expQ1.size() != 0) && cycles < 200) begin
      #1;
      if (rspValid[0]) begin
        expData = (expQ0.size() != 0) ? expQ0.pop_front() : 32'hDEADBEEF;
        checkCount++;
        if (rspData[0] !== expData)
          $display("[TB] FAIL contention_rsp0: got %h, expected %h", rspData[0], expData);
        else passCount++;
      end
      if (rspValid[1]) begin
        expData = (expQ1.size() != 0) ? expQ1.pop_front() : 32'hDEADBEEF;
        checkCount++;
        if (rspData[1] !== expData)
          $display("[TB] FAIL contention_rsp1: got %h, expected %h", rspData[1], expData);
        else passCount++;
      end
      if (reqReady[0] && reqReady[1]) begin
        checkCount++;
        $display("[TB] FAIL contention_double_ready: got both ready, expected one");
      end else if (reqReady[0] || reqReady[1]) begin
        g = reqReady[1];
        expG = (reqValid[0] && reqValid[1]) ? ~lastG : reqValid[1];
        checkCount++;
        if (g !== expG)
          $display("[TB] FAIL contention_grant: got requester %0d, expected %0d", g, expG);
        else passCount++;
        if (reqValid[0] && reqValid[1]) conflicts++;
        if (g) expQ1.push_back(refAlu(opA[1][cnt[1]], opB[1][cnt[1]], 4'd1, 1'b0));
        else   expQ0.push_back(refAlu(opA[0][cnt[0]], opB[0][cnt[0]], 4'd0, 1'b0));
        cnt[g]++;
        pend[g] = 1'b1;
        lastG = g;
      end
      @(negedge clk);
      cycles++;
      for (int s = 0; s < 2; s++) begin
        if (pend[s]) begin
          pend[s] = 1'b0;
          if (cnt[s] < 4) applyStimulus(s, opA[s][cnt[s]], opB[s][cnt[s]], 4'(s), 1'b0);
          else reqValid[s] = 1'b0;
        end
      end
    end
    checkCount++;
    if (cnt[0] != 4 || cnt[1] != 4 || expQ0.size() != 0 || expQ1.size() != 0)
      $display("[TB] FAIL contention_complete: got grants %0d/%0d pending %0d/%0d, expected 4/4 and 0/0",
               cnt[0], cnt[1], expQ0.size(), expQ1.size());
    else passCount++;
`ifdef ALU_ARB_STATS_EN
    checkCount++;
    if (conflictCnt !== 16'(conflicts))
      $display("[TB] FAIL conflict_cnt: got %0d, expected %0d", conflictCnt, conflicts);
    else passCount++;
`endif
    reqValid[0] = 1'b0;
    reqValid[1] = 1'b0;
    rspReady[0] = 1'b0;
    rspReady[1] = 1'b0;
  endtask

  // A lone add from requester 0 with exact latency and routing.
  task automatic test_single_op();
    bit acc, early, got, other;
    logic [31:0] data, s1, s2;
    runOp(0, 32'd5, 32'd3, 4'd0, 1'b0, acc, early, got, data, other, s1, s2);
    checkCount++;
    if ({acc, early, got, other} !== 4'b1010)
      $display("[TB] FAIL single_handshake: got acc/early/valid/other=%b, expected 1010",
               {acc, early, got, other});
    else passCount++;
    checkCount++;
    if (data !== 32'd8)
      $display("[TB] FAIL single_data: got %h, expected 00000008", data);
    else passCount++;
    checkCount++;
    if (s1 !== 32'd5 || s2 !== 32'd3)
      $display("[TB] FAIL single_alu_operands: got %h/%h, expected 00000005/00000003", s1, s2);
    else passCount++;
  endtask

  // Signed vs unsigned compare and the arithmetic shift, on requester 1.
  task automatic test_compare();
    bit acc, early, got, other;
    logic [31:0] data, s1, s2;
    runOp(1, 32'hFFFFFFFF, 32'd1, 4'd11, 1'b1, acc, early, got, data, other, s1, s2);
    checkCount++;
    if (!got || data !== 32'd1)
      $display("[TB] FAIL compare_signed: got valid=%b data=%h, expected 1/00000001", got, data);
    else passCount++;
    runOp(1, 32'hFFFFFFFF, 32'd1, 4'd11, 1'b0, acc, early, got, data, other, s1, s2);
    checkCount++;
    if (!got || data !== 32'd0)
      $display("[TB] FAIL compare_unsigned: got valid=%b data=%h, expected 1/00000000", got, data);
    else passCount++;
    runOp(1, 32'd4, 32'h80000000, 4'd10, 1'b0, acc, early, got, data, other, s1, s2);
    checkCount++;
    if (!got || data !== 32'hF8000000 || other)
      $display("[TB] FAIL shift: got valid=%b data=%h other=%b, expected 1/f8000000/0",
               got, data, other);
    else passCount++;
  endtask

  // An undefined control code still completes a normal handshake with 0.
  task automatic test_undefined();
    bit acc, early, got, other;
    logic [31:0] data, s1, s2;
    runOp(0, 32'd7, 32'd9, 4'd2, 1'b0, acc, early, got, data, other, s1, s2);
    checkCount++;
    if (!acc || !got || data !== 32'd0)
      $display("[TB] FAIL undefined_ctl: got acc=%b valid=%b data=%h, expected 1/1/00000000",
               acc, got, data);
    else passCount++;
  endtask

  // Requester 0 stalls its response; requester 1 must wait, then win the tie.
  task automatic test_back_to_back();
    logic [31:0] a0, b0, a1, b1, a2, b2;
    a0 = $urandom; b0 = $urandom;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom;
    rspReady[0] = 1'b0;
    @(negedge clk);
    applyStimulus(0, a0, b0, 4'd0, 1'b0);
    #1;
    checkCount++;
    if (reqReady[0] !== 1'b1)
      $display("[TB] FAIL bp_accept0: got ready=%b, expected 1", reqReady[0]);
    else passCount++;
    @(negedge clk);
    reqValid[0] = 1'b0;
    applyStimulus(1, a1, b1, 4'd1, 1'b0);
    rspReady[1] = 1'b1;
    #1;
    checkCount++;
    if (reqReady[1] !== 1'b0)
      $display("[TB] FAIL bp_exec_ready1: got %b, expected 0", reqReady[1]);
    else passCount++;
    @(negedge clk);
    applyStimulus(0, a2, b2, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkCount++;
      if (rspValid[0] !== 1'b1 || rspData[0] !== a0 + b0 || reqReady[1] !== 1'b0 ||
          reqReady[0] !== 1'b0 || rspValid[1] !== 1'b0)
        $display("[TB] FAIL bp_hold%0d: got v0=%b d0=%h rdy1=%b rdy0=%b v1=%b, expected 1/%h/0/0/0",
                 i, rspValid[0], rspData[0], reqReady[1], reqReady[0], rspValid[1], a0 + b0);
      else passCount++;
    end
    rspReady[0] = 1'b1;
    @(negedge clk);
    rspReady[0] = 1'b0;
    rspReady[1] = 1'b0;
    #1;
    checkCount++;
    if (reqReady[1] !== 1'b1 || reqReady[0] !== 1'b0)
      $display("[TB] FAIL bp_next_grant: got rdy0=%b rdy1=%b, expected 0/1", reqReady[0], reqReady[1]);
    else passCount++;
    @(negedge clk);
    reqValid[1] = 1'b0;
    @(negedge clk);
    #1;
    checkCount++;
    if (rspValid[1] !== 1'b1 || rspData[1] !== a1 - b1)
      $display("[TB] FAIL bp_rsp1: got v1=%b d1=%h, expected 1/%h", rspValid[1], rspData[1], a1 - b1);
    else passCount++;
    rspReady[1] = 1'b1;
    @(negedge clk);
    rspReady[1] = 1'b0;
    #1;
    checkCount++;
    if (reqReady[0] !== 1'b1)
      $display("[TB] FAIL bp_ready0_after: got %b, expected 1", reqReady[0]);
    else passCount++;
    @(negedge clk);
    reqValid[0] = 1'b0;
    @(negedge clk);
    #1;
    checkCount++;
    if (rspValid[0] !== 1'b1 || rspData[0] !== a2 + b2)
      $display("[TB] FAIL bp_rsp0b: got v0=%b d0=%h, expected 1/%h", rspValid[0], rspData[0], a2 + b2);
    else passCount++;
    rspReady[0] = 1'b1;
    @(negedge clk);
    rspReady[0] = 1'b0;
  endtask

  // Reset during EXEC and during RESP discards the operation; afterwards a
  // tie must again go to requester 0.
  task automatic test_reset_midop();
    for (int phase = 0; phase < 2; phase++) begin
      @(negedge clk);
      applyStimulus(0, 32'd11, 32'd22, 4'd0, 1'b0);
      @(negedge clk);
      reqValid[0] = 1'b0;
      if (phase == 1) @(negedge clk);
      #1;
      checkCount++;
      if (phase == 0 ? (aluIn1 !== 32'd11) : (rspValid[0] !== 1'b1))
        $display("[TB] FAIL midop_pre%0d: got in1=%h v0=%b, expected op in flight",
                 phase, aluIn1, rspValid[0]);
      else passCount++;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if ({aluIn1, aluIn2, aluCtl, aluSign, rspValid[0], rspValid[1], rspData[0], rspData[1]} !== '0)
        $display("[TB] FAIL midop_reset%0d: got in1=%h v0=%b v1=%b d0=%h, expected all 0",
                 phase, aluIn1, rspValid[0], rspValid[1], rspData[0]);
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checkCount++;
      if (rspValid[0] !== 1'b0 || rspValid[1] !== 1'b0)
        $display("[TB] FAIL midop_no_rsp%0d: got v0=%b v1=%b, expected 0/0", phase, rspValid[0], rspValid[1]);
      else passCount++;
      @(negedge clk);
      applyStimulus(0, 32'd100, 32'd1, 4'd1, 1'b0);
      applyStimulus(1, 32'd200, 32'd2, 4'd0, 1'b0);
      #1;
      checkCount++;
      if (reqReady[0] !== 1'b1 || reqReady[1] !== 1'b0)
        $display("[TB] FAIL midop_tie%0d: got rdy0=%b rdy1=%b, expected 1/0", phase, reqReady[0], reqReady[1]);
      else passCount++;
      @(negedge clk);
      reqValid[0] = 1'b0;
      reqValid[1] = 1'b0;
      @(negedge clk);
      #1;
      checkCount++;
      if (rspValid[0] !== 1'b1 || rspData[0] !== 32'd99)
        $display("[TB] FAIL midop_after%0d: got v0=%b d0=%h, expected 1/00000063", phase, rspValid[0], rspData[0]);
      else passCount++;
      rspReady[0] = 1'b1;
      @(negedge clk);
      rspReady[0] = 1'b0;
    end
  endtask

  // Random single operations on random requesters against the reference ALU.
  task automatic test_random();
    logic [3:0] codes [4];
    bit acc, early, got, other;
    logic [31:0] data, s1, s2, a, b, expData;
    logic [3:0] c;
    logic s;
    int side;
    codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd10; codes[3] = 4'd11;
    for (int i = 0; i < 8; i++) begin
      side = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      c = codes[$urandom_range(0, 3)];
      s = 1'($urandom_range(0, 1));
      expData = refAlu(a, b, c, s);
      runOp(side, a, b, c, s, acc, early, got, data, other, s1, s2);
      checkCount++;
      if (!acc || early || !got || other || data !== expData)
        $display("[TB] FAIL random%0d side%0d ctl%0d: got acc=%b early=%b valid=%b other=%b data=%h, expected 1/0/1/0/%h",
                 i, side, c, acc, early, got, other, data, expData);
      else passCount++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 1'b0;
      reqIn1[s]   = '0;
      reqIn2[s]   = '0;
      reqCtl[s]   = '0;
      reqSign[s]  = 1'b0;
      rspReady[s] = 1'b0;
    end
    test_reset();
    test_contention();
    test_single_op();
    test_compare();
    test_undefined();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
